// File: rtl/sdram_device_responder_if.sv
// Command/address/mask bundle of the SDR SDRAM bus between controller and device.
// dq is kept as a plain inout on the responder so tristate resolution stays at module level.
interface sdram_device_responder_if;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic        cke;
  logic [1:0]  dqm;

  modport master (output addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm);
  modport slave  (input  addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm);
endinterface

// File: rtl/sdram_device_responder.sv
// Device-side SDR SDRAM model: command decode, per-bank row state, CAS-latency read pipeline,
// reduced backing array and sticky protocol-violation reporting.
module sdram_device_responder #(
  parameter int unsigned ROW_W    = 4,
  parameter int unsigned COL_W    = 9,
  parameter int unsigned CL_RESET = 3
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  sdram_device_responder_if.slave  sdram_wire,
  inout  wire  [15:0]              sdram_wire_dq,
  output logic                     mode_loaded,
  output logic                     protocol_err,
  output logic [2:0]               err_code
);

  localparam int unsigned IdxW  = 2 + ROW_W + COL_W;
  localparam int unsigned Depth = 1 << IdxW;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [3:0]       r_open;
  logic [ROW_W-1:0] r_row [4];
  logic [1:0]       r_cl;
  logic             r_mode_loaded;
  logic             r_err;
  logic [2:0]       r_err_code;
  logic [15:0]      r_mem [Depth];

  logic             r_pv [3];
  logic [15:0]      r_pd [3];
  logic [1:0]       r_pm [3];
  logic             r_ov;
  logic [15:0]      r_od;
  logic [1:0]       r_om;

  logic [3:0]       w_cmd;
  logic             w_active, w_read, w_write, w_pre, w_refresh, w_lmr;
  logic             w_bank_open, w_access, w_acc_ok, w_lmr_ok;
  logic [IdxW-1:0]  w_idx;
  logic [2:0]       w_err;
  logic [1:0]       w_dq_oe;
  logic             w_unused;

  // Asynchronous assert, release synchronised to clk_clk.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_cmd     = {sdram_wire.cs_n, sdram_wire.ras_n, sdram_wire.cas_n, sdram_wire.we_n};
  assign w_active  = sdram_wire.cke && (w_cmd == 4'b0011);
  assign w_read    = sdram_wire.cke && (w_cmd == 4'b0101);
  assign w_write   = sdram_wire.cke && (w_cmd == 4'b0100);
  assign w_pre     = sdram_wire.cke && (w_cmd == 4'b0010);
  assign w_refresh = sdram_wire.cke && (w_cmd == 4'b0001);
  assign w_lmr     = sdram_wire.cke && (w_cmd == 4'b0000);

  assign w_bank_open = r_open[sdram_wire.ba];
  assign w_access    = w_read || w_write;
  assign w_acc_ok    = w_access && r_mode_loaded && w_bank_open;
  assign w_lmr_ok    = ((sdram_wire.addr[6:4] == 3'd2) || (sdram_wire.addr[6:4] == 3'd3)) &&
                       (sdram_wire.addr[2:0] == 3'd0);
  assign w_idx       = {sdram_wire.ba, r_row[sdram_wire.ba], sdram_wire.addr[COL_W-1:0]};
  assign w_unused    = ^{sdram_wire.addr[12:11], sdram_wire.addr[9]};

  always_comb begin
    w_err = 3'd0;
    if (w_access && !r_mode_loaded)     w_err = 3'd1;
    else if (w_access && !w_bank_open)  w_err = 3'd2;
    else if (w_write && r_ov)           w_err = 3'd6;
    else if (w_active && w_bank_open)   w_err = 3'd3;
    else if (w_refresh && (|r_open))    w_err = 3'd4;
    else if (w_lmr && !w_lmr_ok)        w_err = 3'd5;
  end

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_open        <= 4'b0000;
      for (int i = 0; i < 4; i++) r_row[i] <= '0;
      r_cl          <= 2'(CL_RESET);
      r_mode_loaded <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 3'd0;
    end else begin
      if (w_err != 3'd0) begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_err;
      end
      if (w_lmr && w_lmr_ok) begin
        r_cl          <= sdram_wire.addr[5:4];
        r_mode_loaded <= 1'b1;
      end
      if (w_active) begin
        r_open[sdram_wire.ba] <= 1'b1;
        r_row[sdram_wire.ba]  <= sdram_wire.addr[ROW_W-1:0];
      end
      if (w_pre) begin
        if (sdram_wire.addr[10]) r_open <= 4'b0000;
        else                     r_open[sdram_wire.ba] <= 1'b0;
      end
      if (w_acc_ok && sdram_wire.addr[10]) r_open[sdram_wire.ba] <= 1'b0;
    end
  end

  // Backing store is deliberately left uninitialised across reset.
  always_ff @(posedge clk_clk) begin
    if (w_write && w_acc_ok) begin
      if (!sdram_wire.dqm[0]) r_mem[w_idx][7:0]  <= sdram_wire_dq[7:0];
      if (!sdram_wire.dqm[1]) r_mem[w_idx][15:8] <= sdram_wire_dq[15:8];
    end
  end

  // A READ enters at stage CL-1 so it reaches the output register CL edges later.
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pm[i] <= '0;
      end
      r_ov <= 1'b0;
      r_od <= '0;
      r_om <= '0;
    end else if (sdram_wire.cke) begin
      r_ov    <= r_pv[0];
      r_od    <= r_pd[0];
      r_om    <= r_pm[0];
      r_pv[0] <= r_pv[1];
      r_pd[0] <= r_pd[1];
      r_pm[0] <= r_pm[1];
      r_pv[1] <= r_pv[2];
      r_pd[1] <= r_pd[2];
      r_pm[1] <= r_pm[2];
      r_pv[2] <= 1'b0;
      if (w_read && w_acc_ok) begin
        r_pv[r_cl - 2'd1] <= 1'b1;
        r_pd[r_cl - 2'd1] <= r_mem[w_idx];
        r_pm[r_cl - 2'd1] <= sdram_wire.dqm;
      end
    end
  end

  assign w_dq_oe              = {2{r_ov}} & ~r_om;
  assign sdram_wire_dq[7:0]   = w_dq_oe[0] ? r_od[7:0]  : 8'hzz;
  assign sdram_wire_dq[15:8]  = w_dq_oe[1] ? r_od[15:8] : 8'hzz;

  assign mode_loaded  = r_mode_loaded;
  assign protocol_err = r_err;
  assign err_code     = r_err_code;

endmodule
